// File: rtl/lif_neuron_array.sv
// Leaky integrate-and-fire neuron with masked multi-channel input,
// selectable leak, run-time threshold, refractory period and spike counter.
module lif_neuron_array #(
    parameter int N_IN       = 4,
    parameter int IN_W       = 4,
    parameter int POT_W      = 8,
    parameter int LEAK_SHIFT = 2,
    parameter int REFRACT    = 2,
    parameter int CNT_W      = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [N_IN*IN_W-1:0]   in_data,
    input  logic [N_IN-1:0]        in_mask,
    input  logic [POT_W-1:0]       threshold,
    input  logic [POT_W-1:0]       leak,
    input  logic                   leak_mode,
    input  logic                   reset_mode,
    output logic [POT_W-1:0]       state,
    output logic                   spike,
    output logic                   refractory,
    output logic [CNT_W-1:0]       spike_count
);

    localparam int SUM_W = IN_W + $clog2(N_IN);
    localparam int INT_W = POT_W + SUM_W;
    localparam int RC_W  = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;

    logic [POT_W-1:0] state_q, state_d;
    logic             spike_q, spike_d;
    logic [RC_W-1:0]  rc_q, rc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [SUM_W-1:0] sum;
    logic [POT_W-1:0] leaked;
    logic [INT_W-1:0] integ_w;
    logic [POT_W-1:0] integ;
    logic             fire;

    always_comb begin
        sum = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (in_mask[i]) begin
                sum = sum + SUM_W'(in_data[i*IN_W +: IN_W]);
            end
        end
    end

    always_comb begin
        leaked = '0;
        if (leak_mode) begin
            leaked = state_q - (state_q >> LEAK_SHIFT);
        end else if (state_q > leak) begin
            leaked = state_q - leak;
        end
    end

    // Widened add so saturation can be detected before the threshold compare.
    assign integ_w = {{SUM_W{1'b0}}, leaked} + {{POT_W{1'b0}}, sum};
    assign integ   = (integ_w > {{SUM_W{1'b0}}, {POT_W{1'b1}}})
                     ? {POT_W{1'b1}} : integ_w[POT_W-1:0];
    assign fire    = (threshold != '0) && (integ >= threshold);

    always_comb begin
        state_d = state_q;
        spike_d = 1'b0;
        rc_d    = rc_q;
        cnt_d   = cnt_q;
        if (en) begin
            if (rc_q != '0) begin
                state_d = leaked;
                rc_d    = rc_q - 1'b1;
            end else if (fire) begin
                spike_d = 1'b1;
                state_d = reset_mode ? (integ - threshold) : '0;
                rc_d    = RC_W'(REFRACT);
                if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                state_d = integ;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= '0;
            spike_q <= 1'b0;
            rc_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            spike_q <= spike_d;
            rc_q    <= rc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign state       = state_q;
    assign spike       = spike_q;
    assign refractory  = (rc_q != '0);
    assign spike_count = cnt_q;

endmodule
